jtag_user_regbank: RTL and testbench

- TCK-domain command decoder and register bank on the user data register of the JTAG TAP.
- Consumes the TAP's user data output and update strobe. Drives the TAP's user data input, which the TAP captures on the next Capture-DR.
- Gives a host-driven JTAG path for reading and writing NUM_REGS 32-bit configuration registers, which are exported to the rest of the design.

---
 rtl/jtag_user_regbank.sv | 140 ++++++++++++++
 tb/tb_jtag_user_regbank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_user_regbank.sv
// TCK-domain command decoder and 32-bit register bank behind the JTAG user data register.
// Define JTAG_REGBANK_ERRCNT_EN to add the saturating error counter reported by NOP.
module jtag_user_regbank #(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000,
  parameter logic [31:0] ID_WORD   = 32'he6712945,
  parameter logic [31:0] BAD_READ  = 32'hDEAD_BEEF
) (
  input  logic                     tck,
  input  logic                     w_trst,
  input  logic                     user_op,
  input  logic [31:0]              user_data_out,
  output logic [31:0]              user_data_in,
  output logic                     busy,
  output logic                     wr_strobe,
  output logic [5:0]               wr_addr,
  output logic [NUM_REGS*32-1:0]   regs_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WDATA = 1'b1;

  logic [0:0]  state;
  logic [5:0]  ptr;
  logic [15:0] remaining;
  logic [31:0] regs [NUM_REGS];
  logic [1:0]  cmd;
  logic [5:0]  addr;
  logic [15:0] count;
  logic [5:0]  rd_idx;
  logic [31:0] rd_word;
  logic [7:0]  err_field;
  logic        unused_bits;

  assign cmd         = user_data_out[31:30];
  assign addr        = user_data_out[29:24];
  assign count       = user_data_out[15:0];
  assign unused_bits = ^user_data_out[23:16];

  // The 7-bit sum lets ptr wrap at 64 first and at NUM_REGS otherwise.
  function automatic logic [5:0] ptr_next(input logic [5:0] p);
    logic [6:0] n;
    n = {1'b0, p} + 7'd1;
    if (n == 7'(NUM_REGS)) n = 7'd0;
    return n[5:0];
  endfunction

  function automatic logic in_range(input logic [5:0] a);
    return ({1'b0, a} < 7'(NUM_REGS));
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign rd_idx = (cmd == 2'b11) ? ptr : addr;

  always_comb begin
    rd_word = BAD_READ;
    for (int k = 0; k < NUM_REGS; k++)
      if (rd_idx == 6'(k)) rd_word = regs[k];
  end

`ifdef JTAG_REGBANK_ERRCNT_EN
  logic [7:0] err_cnt;
  logic       err_inc;
  logic       err_clr;

  assign err_inc = user_op && (((state == ST_WDATA) && !in_range(ptr)) ||
                               ((state == ST_IDLE) && cmd[1] && !in_range(rd_idx)));
  assign err_clr = user_op && (state == ST_IDLE) && (cmd == 2'b00) && (addr == 6'h3F);

  always_ff @(posedge tck or negedge w_trst) begin
    if (!w_trst)      err_cnt <= 8'h00;
    else if (err_clr) err_cnt <= 8'h00;
    else if (err_inc) err_cnt <= sat_inc(err_cnt);
  end

  assign err_field = err_cnt;
`else
  assign err_field = 8'h00;
`endif

  always_ff @(posedge tck or negedge w_trst) begin
    if (!w_trst) begin
      state        <= ST_IDLE;
      ptr          <= 6'd0;
      remaining    <= 16'd0;
      user_data_in <= ID_WORD;
      busy         <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= 6'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (user_op) begin
        if (state == ST_WDATA) begin
          if (in_range(ptr)) begin
            wr_strobe <= 1'b1;
            wr_addr   <= ptr;
          end
          ptr       <= ptr_next(ptr);
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end else begin
          case (cmd)
            2'b00: user_data_in <= {8'hA5, 7'b0, busy, 2'b0, ptr, err_field};
            2'b01: begin
              ptr       <= addr;
              remaining <= (count == 16'd0) ? 16'd1 : count;
              state     <= ST_WDATA;
              busy      <= 1'b1;
            end
            default: begin
              user_data_in <= rd_word;
              ptr          <= ptr_next(rd_idx);
            end
          endcase
        end
      end
    end
  end

  // Register bank: written only by in-range WDATA words.
  always_ff @(posedge tck or negedge w_trst) begin
    if (!w_trst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
    end else if (user_op && (state == ST_WDATA)) begin
      for (int k = 0; k < NUM_REGS; k++)
        if (ptr == 6'(k)) regs[k] <= user_data_out;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_jtag_user_regbank.sv
// Randomized bench for jtag_user_regbank against a behavioural model of the command protocol.
module tb_jtag_user_regbank;
  localparam int NR = 8;

  logic              tck;
  logic              w_trst;
  logic              user_op;
  logic [31:0]       user_data_out;
  logic [31:0]       user_data_in;
  logic              busy;
  logic              wr_strobe;
  logic [5:0]        wr_addr;
  logic [NR*32-1:0]  regs_o;

  int n_cmp;
  int n_bad;

  bit          m_wdata;
  int          m_ptr;
  int          m_rem;
  int          m_err;
  logic [31:0] m_regs [NR];
  logic [31:0] m_udi;
  bit          m_strb;
  int          m_waddr;

  jtag_user_regbank #(.NUM_REGS(NR)) dut (
    .tck(tck), .w_trst(w_trst), .user_op(user_op), .user_data_out(user_data_out),
    .user_data_in(user_data_in), .busy(busy), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .regs_o(regs_o)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int p);
    int n;
    n = (p + 1) % 64;
    if (n == NR) n = 0;
    return n;
  endfunction

  function automatic logic [7:0] errf();
`ifdef JTAG_REGBANK_ERRCNT_EN
    return 8'(m_err);
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [255:0] mdl_regs();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = m_regs[k];
    return v;
  endfunction

  task automatic mdl_reset();
    m_wdata = 0; m_ptr = 0; m_rem = 0; m_err = 0;
    m_udi = 32'he6712945; m_strb = 0; m_waddr = 0;
    for (int k = 0; k < NR; k++) m_regs[k] = 32'h0;
  endtask

  task automatic mdl_op(input logic [31:0] w);
    int cmd, a, c, idx;
    m_strb = 0;
    if (m_wdata) begin
      if (m_ptr < NR) begin
        m_regs[m_ptr] = w;
        m_strb = 1;
        m_waddr = m_ptr;
      end else if (m_err < 255) m_err++;
      m_ptr = nxt(m_ptr);
      m_rem--;
      if (m_rem == 0) m_wdata = 0;
    end else begin
      cmd = int'(w[31:30]);
      a   = int'(w[29:24]);
      c   = int'(w[15:0]);
      case (cmd)
        0: begin
          m_udi = {8'hA5, 7'b0, m_wdata, 2'b0, 6'(m_ptr), errf()};
          if (a == 63) m_err = 0;
        end
        1: begin
          m_ptr = a;
          m_rem = (c == 0) ? 1 : c;
          m_wdata = 1;
        end
        default: begin
          idx = (cmd == 2) ? a : m_ptr;
          if (idx < NR) m_udi = m_regs[idx];
          else begin
            m_udi = 32'hDEADBEEF;
            if (m_err < 255) m_err++;
          end
          m_ptr = nxt(idx);
        end
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".udi"},   256'(user_data_in), 256'(m_udi));
    chk({tag, ".busy"},  256'(busy),         256'(m_wdata));
    chk({tag, ".strb"},  256'(wr_strobe),    256'(m_strb));
    chk({tag, ".waddr"}, 256'(wr_addr),      256'(6'(m_waddr)));
    chk({tag, ".regs"},  256'(regs_o),       mdl_regs());
  endtask

  task automatic send(input logic [31:0] w, input string tag);
    @(negedge tck);
    user_op = 1'b1;
    user_data_out = w;
    @(posedge tck);
    #1;
    mdl_op(w);
    check_all(tag);
  endtask

  task automatic gap();
    @(negedge tck);
    user_op = 1'b0;
    user_data_out = $urandom;
    @(posedge tck);
    #1;
    m_strb = 0;
    check_all("gap");
  endtask

  task automatic do_reset(input string tag);
    @(negedge tck);
    user_op = 1'b0;
    #2 w_trst = 1'b0;
    #1;
    mdl_reset();
    check_all(tag);
    @(negedge tck);
    w_trst = 1'b1;
  endtask

  function automatic logic [31:0] mk(input int cmd, input int a, input int c);
    return {2'(cmd), 6'(a), 8'($urandom), 16'(c)};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    user_op = 1'b0;
    user_data_out = 32'h0;
    w_trst = 1'b0;
    mdl_reset();
    #12;
    w_trst = 1'b1;
    gap();
    chk("rst_id", 256'(user_data_in), 256'(32'he6712945));
    chk("rst_regs", 256'(regs_o), 256'(0));

    send(mk(1, 2, 3), "wr_cmd");
    send(32'h11111111, "wr_d0");
    chk("wr_d0_addr", 256'(wr_addr), 256'(6'd2));
    send(32'h22222222, "wr_d1");
    send(32'h33333333, "wr_d2");
    chk("wr_busy_fall", 256'(busy), 256'(0));
    chk("wr_reg4", 256'(regs_o[4*32 +: 32]), 256'(32'h33333333));
    send(mk(2, 3, 0), "rd3");
    chk("rd3_val", 256'(user_data_in), 256'(32'h22222222));
    send(mk(3, 0, 0), "rdn");
    chk("rdn_val", 256'(user_data_in), 256'(32'h33333333));

    send(mk(1, 7, 2), "wrap_cmd");
    send(32'hAAAA0000, "wrap_d0");
    send(32'hBBBB0000, "wrap_d1");
    chk("wrap_reg0", 256'(regs_o[31:0]), 256'(32'hBBBB0000));
    chk("wrap_reg7", 256'(regs_o[7*32 +: 32]), 256'(32'hAAAA0000));

    send(mk(2, 9, 0), "rd_bad");
    chk("rd_bad_val", 256'(user_data_in), 256'(32'hDEADBEEF));
    send(mk(0, 63, 0), "nop_err");
`ifdef JTAG_REGBANK_ERRCNT_EN
    chk("nop_errf", 256'(user_data_in[7:0]), 256'(8'h01));
`else
    chk("nop_errf", 256'(user_data_in[7:0]), 256'(8'h00));
`endif
    chk("nop_hdr", 256'(user_data_in[31:24]), 256'(8'hA5));

    send(mk(1, 0, 4), "mid_cmd");
    send(32'h5A5A5A5A, "mid_d0");
    do_reset("mid_rst");
    chk("mid_rst_busy", 256'(busy), 256'(0));
    send(mk(2, 0, 0), "mid_after");
    chk("mid_after_val", 256'(user_data_in), 256'(32'h0));
    gap();

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) gap();
      else if (r < 10) do_reset("rnd_rst");
      else if (m_wdata) send($urandom, "rnd_data");
      else begin
        int cmd, a, c;
        cmd = $urandom_range(0, 3);
        a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, NR - 1);
        c = $urandom_range(0, 5);
        send(mk(cmd, a, c), "rnd_cmd");
      end
    end
    gap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
